// File: rtl/uart_tx_frame_arb.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between NUM_REQ
// telemetry sources. Each grant sends a 3-byte frame (header, word MSB,
// word LSB) and is followed by an enforced idle gap before the next grant.
module uart_tx_frame_arb #(
    parameter int         NUM_REQ    = 2,
    parameter logic [7:0] HDR_BASE   = 8'hA0,
    parameter int         GAP_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   payload,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    busy,
    output logic                    trmt,
    output logic [7:0]              tx_data,
    input  logic                    tx_done
);

    localparam int IW = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    byte_idx;
    logic [IW-1:0] gnt_id;
    logic [IW-1:0] last;
    logic [15:0]   word;
    logic [GW-1:0] gap_cnt;
    logic          wait_first;   // first WAIT cycle: tx_done may still be stale

    logic          found;
    logic [IW-1:0] next_id;
    logic [IW-1:0] cand;
    logic          grant;

    // Pick the first requester after the last grant, wrapping around.
    always_comb begin
        found   = 1'b0;
        next_id = '0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                found   = 1'b1;
                next_id = cand;
            end
        end
    end

    assign grant = (state == IDLE) && (gap_cnt == GAP_MAX) && found;

    // A byte is launched exactly in the single SEND cycle.
    assign trmt = (state == SEND);

    // Frame sequencing, gap timing and ack/busy generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            gnt_id     <= '0;
            last       <= IW'(NUM_REQ - 1);
            word       <= '0;
            gap_cnt    <= GAP_MAX;
            wait_first <= 1'b0;
            ack        <= '0;
            busy       <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_id   <= next_id;
                        last     <= next_id;
                        word     <= payload[16*next_id +: 16];
                        byte_idx <= 2'd0;
                        busy     <= 1'b1;
                        tx_data  <= HDR_BASE + 8'(next_id);
                        state    <= SEND;
                    end else begin
                        // busy stays up through the ack cycle, drops after
                        busy <= 1'b0;
                        if (gap_cnt != GAP_MAX)
                            gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                SEND: begin
                    wait_first <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    wait_first <= 1'b0;
                    if (!wait_first && tx_done) begin
                        if (byte_idx != 2'd2) begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_data  <= (byte_idx == 2'd0) ? word[15:8] : word[7:0];
                            state    <= SEND;
                        end else begin
                            ack     <= NUM_REQ'(1) << gnt_id;
                            gap_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
